// File: rtl/demux_1_to_8_router_pkg.sv
// Shared constants and helpers for the 1-to-8 word router.
package demux_1_to_8_router_pkg;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 16;

    // Low bit index of channel ch inside the flattened out_data bus.
    function automatic int ch_lo(input int ch);
        return ch * DATA_W;
    endfunction

endpackage

// File: rtl/demux_1_to_8_router_channel_slot.sv
// One-entry output register for a single router channel with valid/ready handshake.
// The slot is free when empty or when its current word drains on this edge.
module demux_channel_slot
    import demux_1_to_8_router_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              out_ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              free_o
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Next state: a load wins over a drain; data holds its last value after draining.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot state register with synchronous reset that drops any held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= {DATA_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign free_o  = ~valid_q | out_ready_i;

endmodule

// File: rtl/demux_1_to_8_router.sv
// Routes one 32-bit producer stream to 8 registered consumer channels, unicast by
// destination select or broadcast to all, and counts accepted words.
module demux_1_to_8_router
    import demux_1_to_8_router_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    input  logic [DATA_W-1:0]        in_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         accept_count
);

    logic [NUM_CH-1:0] free_s;
    logic [NUM_CH-1:0] target_s;
    logic [NUM_CH-1:0] load_s;
    logic              accept_s;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    // Destination decode, ready selection and per-slot load strobes.
    always_comb begin
        target_s = {NUM_CH{1'b0}};
        in_ready = 1'b0;
        if (in_bcast) begin
            target_s = {NUM_CH{1'b1}};
        end else begin
            target_s = NUM_CH'(1) << in_sel;
        end
        if (reset) begin
            in_ready = 1'b0;
        end else if (in_bcast) begin
            in_ready = &free_s;
        end else begin
            in_ready = free_s[in_sel];
        end
        accept_s = in_valid & in_ready;
        load_s   = target_s & {NUM_CH{accept_s}};
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_slot
            demux_channel_slot u_slot (
                .clk         (clk),
                .reset       (reset),
                .load_i      (load_s[g]),
                .data_i      (in_data),
                .out_ready_i (out_ready[g]),
                .valid_o     (out_valid[g]),
                .data_o      (out_data[ch_lo(g) +: DATA_W]),
                .free_o      (free_s[g])
            );
        end
    endgenerate

    // Accepted-word counter next state; a broadcast counts once, wraps naturally.
    always_comb begin
        if (accept_s) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Accepted-word counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign accept_count = count_q;

endmodule

// File: tb/tb_demux_1_to_8_router.sv
// Self-checking bench for demux_1_to_8_router: vector table, directed corner
// sequences and randomized traffic against a behavioural channel model.
module tb_demux_1_to_8_router;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_sel;
    logic         in_bcast;
    logic [31:0]  in_data;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [255:0] out_data;
    logic [15:0]  accept_count;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: what each channel holds and how many words were taken.
    bit          m_valid [8];
    logic [31:0] m_data  [8];
    logic [15:0] m_count;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] data;
        logic [7:0]  exp_valid;
    } vec_t;
    vec_t vecs [8];

    demux_1_to_8_router dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_bcast     (in_bcast),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .accept_count (accept_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit model_ready();
        bit all_free;
        if (reset) return 1'b0;
        if (in_bcast) begin
            all_free = 1'b1;
            for (int i = 0; i < 8; i++)
                if (m_valid[i] && !out_ready[i]) all_free = 1'b0;
            return all_free;
        end
        return !m_valid[in_sel] || out_ready[in_sel];
    endfunction

    function automatic logic [7:0] model_valid_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_valid[i];
        return v;
    endfunction

    task automatic model_edge();
        bit acc;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_valid[i] = 1'b0;
                m_data[i]  = 32'h0;
            end
            m_count = 16'h0;
        end else begin
            acc = in_valid && model_ready();
            for (int i = 0; i < 8; i++) begin
                if (acc && (in_bcast || in_sel == 3'(i))) begin
                    m_valid[i] = 1'b1;
                    m_data[i]  = in_data;
                end else if (m_valid[i] && out_ready[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (acc) m_count = m_count + 16'd1;
        end
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic step();
        #1;
        chk("in_ready", {31'h0, in_ready}, {31'h0, model_ready()});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("out_valid", {24'h0, out_valid}, {24'h0, model_valid_vec()});
        for (int i = 0; i < 8; i++)
            chk($sformatf("out_data[%0d]", i), out_data[i*32 +: 32], m_data[i]);
        chk("accept_count", {16'h0, accept_count}, {16'h0, m_count});
    endtask

    task automatic drive(input bit v, input logic [2:0] s, input bit b, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_bcast = b;
        in_data  = d;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = 32'h0;
        end
        m_count   = 16'h0;
        reset     = 1'b1;
        out_ready = 8'hFF;
        drive(1'b1, 3'd2, 1'b0, 32'hDEAD_BEEF);

        // Reset held for two cycles with a word offered.
        step();
        step();
        #1;
        chk("reset in_ready", {31'h0, in_ready}, 32'h0);
        chk("reset out_valid", {24'h0, out_valid}, 32'h0);
        chk("reset out_data", {31'h0, |out_data}, 32'h0);
        chk("reset count", {16'h0, accept_count}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Unicast vectors back-to-back, every consumer ready.
        for (int i = 0; i < 8; i++) begin
            vecs[i].sel       = 3'(i);
            vecs[i].data      = 32'hA0 + 32'(i);
            vecs[i].exp_valid = 8'h01 << i;
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].sel, 1'b0, vecs[i].data);
            step();
            chk("vec out_valid", {24'h0, out_valid}, {24'h0, vecs[i].exp_valid});
            chk("vec out_data", out_data[i*32 +: 32], vecs[i].data);
        end
        drive(1'b0, 3'd0, 1'b0, 32'h0);
        step();
        chk("unicast count", {16'h0, accept_count}, 32'd8);
        chk("unicast drained", {24'h0, out_valid}, 32'h0);

        // Backpressure on channel 3.
        out_ready = 8'hF7;
        drive(1'b1, 3'd3, 1'b0, 32'h1111);
        step();
        drive(1'b1, 3'd3, 1'b0, 32'h2222);
        #1;
        chk("bp in_ready low", {31'h0, in_ready}, 32'h0);
        step();
        step();
        chk("bp held data", out_data[3*32 +: 32], 32'h1111);
        out_ready = 8'hFF;
        #1;
        chk("bp in_ready refill", {31'h0, in_ready}, 32'h1);
        step();
        chk("bp refill data", out_data[3*32 +: 32], 32'h2222);
        chk("bp refill valid", {31'h0, out_valid[3]}, 32'h1);
        out_ready = 8'hF7;
        drive(1'b0, 3'd0, 1'b0, 32'h0);
        step();

        // Independence: channel 3 stalled, channel 5 still flows.
        drive(1'b1, 3'd5, 1'b0, 32'h5555);
        #1;
        chk("indep in_ready", {31'h0, in_ready}, 32'h1);
        step();
        chk("indep valid5", {31'h0, out_valid[5]}, 32'h1);
        chk("indep data5", out_data[5*32 +: 32], 32'h5555);

        // Broadcast waits for the full slot 6.
        out_ready = 8'hBF;
        drive(1'b1, 3'd6, 1'b0, 32'h6666);
        step();
        drive(1'b1, 3'd1, 1'b1, 32'hBEEF);
        #1;
        chk("bcast blocked", {31'h0, in_ready}, 32'h0);
        step();
        step();
        chk("bcast slot6 held", out_data[6*32 +: 32], 32'h6666);
        out_ready = 8'hFF;
        #1;
        chk("bcast in_ready", {31'h0, in_ready}, 32'h1);
        step();
        chk("bcast valid", {24'h0, out_valid}, 32'hFF);
        for (int i = 0; i < 8; i++)
            chk("bcast data", out_data[i*32 +: 32], 32'hBEEF);
        chk("bcast count", {16'h0, accept_count}, 32'd13);
        drive(1'b0, 3'd0, 1'b0, 32'h0);
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 7) == 0, $urandom());
            out_ready = 8'($urandom()) | 8'($urandom());
            step();
        end

        // Count up to the wrap point, then one more accept rolls it to zero.
        out_ready = 8'hFF;
        for (int n = 0; n < 70000 && m_count != 16'hFFFF; n++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 1'b0, $urandom());
            step();
        end
        chk("reached FFFF", {16'h0, accept_count}, 32'h0000_FFFF);
        drive(1'b1, 3'd4, 1'b0, 32'h4444);
        step();
        chk("wrap count", {16'h0, accept_count}, 32'h0);

        // Fill four stalled slots, then reset mid-transfer.
        out_ready = 8'h00;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(i), 1'b0, 32'hC0 + 32'(i));
            step();
        end
        chk("four full", {28'h0, out_valid[3:0]}, 32'hF);
        reset = 1'b1;
        drive(1'b1, 3'd5, 1'b0, 32'h7777);
        step();
        chk("midreset valid", {24'h0, out_valid}, 32'h0);
        chk("midreset count", {16'h0, accept_count}, 32'h0);
        chk("midreset data", {31'h0, |out_data}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
